// File: rtl/fhe_alu_pkg.sv
// ---------------------------------------------------------------------------
// fhe_alu_pkg
// Shared constants and types for the FHE ALU root-power tables.
//   E              : butterfly width; a root-power RAM row holds E/2 lanes
//   LOG_E          : number of NTT stages stored per bank
//   N              : twiddle words per stage
//   FSIZE          : twiddle word width
//   ROOT_POWER_NUM : number of root-power banks
//   LOAD_WORDS     : words in one complete table load (LOG_E * N)
// ---------------------------------------------------------------------------
package fhe_alu_pkg;

  localparam int FSIZE          = 64;
  localparam int E              = 8;
  localparam int LOG_E          = 3;
  localparam int N              = 16;
  localparam int ROOT_POWER_NUM = 4;
  localparam int LOAD_WORDS     = LOG_E * N;

  // Loader sequencing: wait for start, stream words, one cycle to signal done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } root_loader_state_t;

  // Index width for a range of 'count' entries; never narrower than one bit.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/loader_addr_counter.sv
// ---------------------------------------------------------------------------
// loader_addr_counter
// Nested position counters for the root-power table loader. The lane counter
// is innermost, then the row address, then the stage. Each advance moves one
// word forward in that order; all three wrap to zero after the final word.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : return all counters to zero (has priority over advance)
//   advance   : step to the next word position
//   lane      : current lane   (0 .. LANES-1)
//   addr      : current row    (0 .. ADDRS-1)
//   stage     : current stage  (0 .. STAGES-1)
//   last      : current position is the final word of the table
// ---------------------------------------------------------------------------
module loader_addr_counter
  import fhe_alu_pkg::*;
#(
  parameter  int LANES  = E / 2,
  parameter  int ADDRS  = N / (E / 2),
  parameter  int STAGES = LOG_E,
  localparam int LANEW  = width_of(LANES),
  localparam int ADDRW  = width_of(ADDRS),
  localparam int STAGEW = width_of(STAGES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              advance,
  output logic [LANEW-1:0]  lane,
  output logic [ADDRW-1:0]  addr,
  output logic [STAGEW-1:0] stage,
  output logic              last
);

  localparam logic [LANEW-1:0]  LANE_MAX  = LANEW'(LANES - 1);
  localparam logic [ADDRW-1:0]  ADDR_MAX  = ADDRW'(ADDRS - 1);
  localparam logic [STAGEW-1:0] STAGE_MAX = STAGEW'(STAGES - 1);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane  <= '0;
      addr  <= '0;
      stage <= '0;
    end else if (clear) begin
      lane  <= '0;
      addr  <= '0;
      stage <= '0;
    end else if (advance) begin
      if (lane == LANE_MAX) begin
        lane <= '0;
        if (addr == ADDR_MAX) begin
          addr <= '0;
          if (stage == STAGE_MAX) begin
            stage <= '0;
          end else begin
            stage <= stage + 1'b1;
          end
        end else begin
          addr <= addr + 1'b1;
        end
      end else begin
        lane <= lane + 1'b1;
      end
    end
  end

  assign last = (lane == LANE_MAX) && (addr == ADDR_MAX) && (stage == STAGE_MAX);

endmodule

// File: rtl/root_power_loader.sv
// ---------------------------------------------------------------------------
// root_power_loader
// Streams a complete twiddle table (W words plus their matching Shoup WQ
// words) into one of several root-power RAM banks. A start pulse selects the
// bank; words then arrive over a valid/ready handshake in stage, row, lane
// order and each accepted word is written one cycle later through a single
// registered write stage. done pulses once after the last word.
//   clk, rstn       : clock, asynchronous active-low reset
//   start, bank_sel : begin a load into bank bank_sel (honoured only in IDLE)
//   abort           : cancel a load in progress, no done pulse
//   in_valid/ready  : word handshake, transfer when both are high
//   in_w, in_wq     : twiddle word and its Shoup companion
//   W_ram_* / WQ_ram_* : per bank, per stage write address, per lane data
//                     and write enables for the W and WQ tables
//   busy            : a load is streaming
//   done            : one-cycle pulse at the end of a completed load
// ---------------------------------------------------------------------------
module root_power_loader
  import fhe_alu_pkg::*;
#(
  parameter  int FSIZE                  = fhe_alu_pkg::FSIZE,
  parameter  int ROOT_POWER_NUM_IN_ROOT = ROOT_POWER_NUM,
  localparam int LANES                  = E / 2,
  localparam int ADDRW                  = width_of(N / LANES),
  localparam int BANKW                  = width_of(ROOT_POWER_NUM_IN_ROOT)
) (
  input  logic                                                          clk,
  input  logic                                                          rstn,
  input  logic                                                          start,
  input  logic [BANKW-1:0]                                              bank_sel,
  input  logic                                                          abort,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  input  logic [FSIZE-1:0]                                              in_w,
  input  logic [FSIZE-1:0]                                              in_wq,
  output logic [ROOT_POWER_NUM_IN_ROOT-1:0][LOG_E-1:0][ADDRW-1:0]             W_ram_waddr,
  output logic [ROOT_POWER_NUM_IN_ROOT-1:0][LOG_E-1:0][ADDRW-1:0]             WQ_ram_waddr,
  output logic [ROOT_POWER_NUM_IN_ROOT-1:0][LOG_E-1:0][LANES-1:0][FSIZE-1:0]  W_ram_wdata,
  output logic [ROOT_POWER_NUM_IN_ROOT-1:0][LOG_E-1:0][LANES-1:0][FSIZE-1:0]  WQ_ram_wdata,
  output logic [ROOT_POWER_NUM_IN_ROOT-1:0][LOG_E-1:0][LANES-1:0]             W_ram_wren,
  output logic [ROOT_POWER_NUM_IN_ROOT-1:0][LOG_E-1:0][LANES-1:0]             WQ_ram_wren,
  output logic                                                          busy,
  output logic                                                          done
);

  localparam int LANEW  = width_of(LANES);
  localparam int STAGEW = width_of(LOG_E);

  root_loader_state_t  state;
  logic [BANKW-1:0]    bank_q;
  logic [LANEW-1:0]    lane;
  logic [ADDRW-1:0]    addr;
  logic [STAGEW-1:0]   stage;
  logic                last;
  logic                fire;
  logic                cnt_clear;

  // Handshake and status decode straight from the state register.
  assign in_ready  = (state == LOAD);
  assign busy      = (state == LOAD);
  assign fire      = in_valid && in_ready;
  // Counters return to zero naturally after the last word; only an abort
  // can leave them mid-table.
  assign cnt_clear = abort && (state != IDLE);

  loader_addr_counter #(
    .LANES  (LANES),
    .ADDRS  (N / LANES),
    .STAGES (LOG_E)
  ) u_counter (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (cnt_clear),
    .advance (fire),
    .lane    (lane),
    .addr    (addr),
    .stage   (stage),
    .last    (last)
  );

  // Sequencer. abort wins over completion, so an aborted load never reports
  // done even when the aborting cycle carries the final word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      bank_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            bank_q <= bank_sel;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (fire && last) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= IDLE;
          done  <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered write stage: one enable bit per accepted word, addressed by
  // the latched bank and the counter position at acceptance time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the data and address registers are reset as well as the
      // enables, so downstream RAM ports never see unknown values.
      W_ram_wren   <= '0;
      WQ_ram_wren  <= '0;
      W_ram_waddr  <= '0;
      WQ_ram_waddr <= '0;
      W_ram_wdata  <= '0;
      WQ_ram_wdata <= '0;
    end else begin
      // NOTE: the default clear followed by a targeted set relies on the last
      // non-blocking assignment to a bit winning, giving a one-hot enable.
      W_ram_wren  <= '0;
      WQ_ram_wren <= '0;
      if (fire) begin
        W_ram_wren  [bank_q][stage][lane] <= 1'b1;
        WQ_ram_wren [bank_q][stage][lane] <= 1'b1;
        W_ram_wdata [bank_q][stage][lane] <= in_w;
        WQ_ram_wdata[bank_q][stage][lane] <= in_wq;
        W_ram_waddr [bank_q][stage]       <= addr;
        WQ_ram_waddr[bank_q][stage]       <= addr;
      end
    end
  end

endmodule
